// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction store: assembles big-endian 16-bit words and writes them.
// Optional trailing XOR checksum when IMEM_LOADER_CHKSUM_EN is defined.
module imem_loader #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Start,
    input  logic        i_Byte_Valid,
    input  logic [7:0]  i_Byte,
    output logic        o_Byte_Ready,
    output logic        o_We,
    output logic [15:0] o_Waddr,
    output logic [15:0] o_Wdata,
    output logic        o_Cpu_Hold,
    output logic        o_Done,
    output logic        o_Err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned CMP_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_HI,
        ST_LO,
        ST_WR,
        ST_DONE,
`ifdef IMEM_LOADER_CHKSUM_EN
        ST_ERR,
        ST_CHK
`else
        ST_ERR
`endif
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [7:0]         len_q;
    logic [7:0]         hi_q;
    logic [CNT_W-1:0]   cnt_q;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0]         xor_q;
`endif

    logic               xfer;
    logic               start_acc;
    logic               last_word;
    logic               ready_d;
    logic               we_d;
    logic               hold_d;
    logic               done_d;
    logic               err_d;

    assign xfer      = i_Byte_Valid & o_Byte_Ready;
    // Compare at 9 bits so N up to 256 and a counter of DEPTH never alias.
    assign last_word = (CMP_W'(cnt_q) + CMP_W'(1)) == CMP_W'(len_q);

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (i_Start) begin
                    state_d   = ST_LEN;
                    start_acc = 1'b1;
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    if ((i_Byte == 8'd0) || (CMP_W'(i_Byte) > CMP_W'(DEPTH))) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_HI;
                    end
                end
            end
            ST_HI: begin
                if (xfer) begin
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (xfer) begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_HI;
                end
            end
`ifdef IMEM_LOADER_CHKSUM_EN
            ST_CHK: begin
                if (xfer) begin
                    state_d = (i_Byte == xor_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        ready_d = 1'b0;
        we_d    = 1'b0;
        hold_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_d)
            ST_LEN, ST_HI, ST_LO: begin
                ready_d = 1'b1;
                hold_d  = 1'b1;
            end
`ifdef IMEM_LOADER_CHKSUM_EN
            ST_CHK: begin
                ready_d = 1'b1;
                hold_d  = 1'b1;
            end
`endif
            ST_WR: begin
                we_d   = 1'b1;
                hold_d = 1'b1;
            end
            ST_DONE: done_d = 1'b1;
            ST_ERR: begin
                done_d = 1'b1;
                err_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q      <= ST_IDLE;
            len_q        <= 8'd0;
            hi_q         <= 8'd0;
            cnt_q        <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
            xor_q        <= 8'd0;
`endif
            o_Byte_Ready <= 1'b0;
            o_We         <= 1'b0;
            o_Waddr      <= 16'd0;
            o_Wdata      <= 16'd0;
            o_Cpu_Hold   <= 1'b0;
            o_Done       <= 1'b0;
            o_Err        <= 1'b0;
        end else begin
            state_q      <= state_d;
            o_Byte_Ready <= ready_d;
            o_We         <= we_d;
            o_Cpu_Hold   <= hold_d;
            o_Done       <= done_d;
            o_Err        <= err_d;

            if (start_acc) begin
                cnt_q <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
                xor_q <= 8'd0;
`endif
            end

            if ((state_q == ST_LEN) && xfer) begin
                len_q <= i_Byte;
            end

            if ((state_q == ST_HI) && xfer) begin
                hi_q <= i_Byte;
`ifdef IMEM_LOADER_CHKSUM_EN
                xor_q <= xor_q ^ i_Byte;
`endif
            end

            // Word and address are captured here so they appear together with o_We.
            if ((state_q == ST_LO) && xfer) begin
                o_Wdata <= {hi_q, i_Byte};
                o_Waddr <= 16'({cnt_q[ADDR_W-1:0], 1'b0});
`ifdef IMEM_LOADER_CHKSUM_EN
                xor_q   <= xor_q ^ i_Byte;
`endif
            end

            if (state_q == ST_WR) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; follows IMEM_LOADER_CHKSUM_EN when defined.
module tb_imem_loader;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    logic        clk = 1'b0;
    logic        i_Rst = 1'b1;
    logic        i_Start = 1'b0;
    logic        i_Byte_Valid = 1'b0;
    logic [7:0]  i_Byte = 8'h00;
    logic        o_Byte_Ready;
    logic        o_We;
    logic [15:0] o_Waddr;
    logic [15:0] o_Wdata;
    logic        o_Cpu_Hold;
    logic        o_Done;
    logic        o_Err;

    int tests = 0;
    int fails = 0;

    logic [15:0] wr_addr[$];
    logic [15:0] wr_data[$];
    logic [15:0] exp_data[$];
    logic [7:0]  bq[$];

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_Clk        (clk),
        .i_Rst        (i_Rst),
        .i_Start      (i_Start),
        .i_Byte_Valid (i_Byte_Valid),
        .i_Byte       (i_Byte),
        .o_Byte_Ready (o_Byte_Ready),
        .o_We         (o_We),
        .o_Waddr      (o_Waddr),
        .o_Wdata      (o_Wdata),
        .o_Cpu_Hold   (o_Cpu_Hold),
        .o_Done       (o_Done),
        .o_Err        (o_Err)
    );

    always #5 clk = ~clk;

    // Log every write strobe of the cycle that just ended.
    always @(posedge clk) begin
        if (o_We === 1'b1) begin
            wr_addr.push_back(o_Waddr);
            wr_data.push_back(o_Wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        i_Start = 1'b1;
        @(negedge clk);
        i_Start = 1'b0;
    endtask

    // Drive bq; a byte advances only when valid and ready met at a rising edge.
    task automatic stream(input bit rnd);
        int  idx   = 0;
        int  guard = 0;
        bit  xfer;
        while (idx < bq.size() && guard < 2000) begin
            i_Byte       = bq[idx];
            i_Byte_Valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            xfer         = i_Byte_Valid && (o_Byte_Ready === 1'b1);
            @(posedge clk);
            if (xfer) idx++;
            @(negedge clk);
            guard++;
        end
        i_Byte_Valid = 1'b0;
        check("stream_bytes_consumed", 32'(idx), 32'(bq.size()));
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (o_Done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(o_Done), 32'd1);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, 32'(wr_addr.size()), 32'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < wr_addr.size(); i++) begin
            check({tag, "_addr"}, 32'(wr_addr[i]), 32'(i * 2));
            check({tag, "_data"}, 32'(wr_data[i]), 32'(exp_data[i]));
        end
    endtask

    task automatic build_normal(input logic [7:0] chk);
        bq.delete();
        bq.push_back(8'h02);
        bq.push_back(8'h80);
        bq.push_back(8'h00);
        bq.push_back(8'h2C);
        bq.push_back(8'hB2);
`ifdef IMEM_LOADER_CHKSUM_EN
        bq.push_back(chk);
`else
        if (chk == 8'hFF) bq.push_back(chk);
        bq = bq[0:4];
`endif
        exp_data.delete();
        exp_data.push_back(16'h8000);
        exp_data.push_back(16'h2CB2);
    endtask

    initial begin
        logic [7:0] x;
        logic [7:0] hb;
        logic [7:0] lb;

        // Reset with valid asserted: everything stays low.
        i_Byte_Valid = 1'b1;
        i_Byte       = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_ready", 32'(o_Byte_Ready), 32'd0);
        end
        check("rst_we", 32'(o_We), 32'd0);
        check("rst_hold", 32'(o_Cpu_Hold), 32'd0);
        check("rst_done", 32'(o_Done), 32'd0);
        check("rst_err", 32'(o_Err), 32'd0);
        check("rst_waddr", 32'(o_Waddr), 32'd0);
        check("rst_wdata", 32'(o_Wdata), 32'd0);
        i_Rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("idle_ready", 32'(o_Byte_Ready), 32'd0);
        i_Byte_Valid = 1'b0;

        // Normal two-word load.
        build_normal(8'h1E);
        wr_addr.delete();
        wr_data.delete();
        do_start();
        check("start_hold", 32'(o_Cpu_Hold), 32'd1);
        check("start_ready", 32'(o_Byte_Ready), 32'd1);
        stream(1'b0);
`ifdef IMEM_LOADER_CHKSUM_EN
        check("norm_done_after_chk", 32'(o_Done), 32'd1);
`else
        check("norm_we_latency", 32'(o_We), 32'd1);
        check("norm_last_waddr", 32'(o_Waddr), 32'h0002);
        check("norm_last_wdata", 32'(o_Wdata), 32'h2CB2);
        @(negedge clk);
        check("norm_done_timing", 32'(o_Done), 32'd1);
        check("norm_we_single", 32'(o_We), 32'd0);
`endif
        check("norm_err", 32'(o_Err), 32'd0);
        check("norm_hold", 32'(o_Cpu_Hold), 32'd0);
        check_writes("norm");

        // Bytes presented after DONE must not be accepted.
        i_Byte_Valid = 1'b1;
        i_Byte       = 8'h77;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_done_ready", 32'(o_Byte_Ready), 32'd0);
        end
        i_Byte_Valid = 1'b0;

        // Length faults: zero and DEPTH+1.
        for (int k = 0; k < 2; k++) begin
            bq.delete();
            bq.push_back((k == 0) ? 8'h00 : 8'h11);
            wr_addr.delete();
            wr_data.delete();
            do_start();
            check("lenf_done_cleared", 32'(o_Done), 32'd0);
            stream(1'b0);
            check("lenf_err", 32'(o_Err), 32'd1);
            check("lenf_done", 32'(o_Done), 32'd1);
            check("lenf_hold", 32'(o_Cpu_Hold), 32'd0);
            repeat (3) @(negedge clk);
            check("lenf_no_we", 32'(wr_addr.size()), 32'd0);
        end

        // Full depth with random data.
        bq.delete();
        exp_data.delete();
        x = 8'h00;
        bq.push_back(8'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            hb = 8'($urandom);
            lb = 8'($urandom);
            bq.push_back(hb);
            bq.push_back(lb);
            x = x ^ hb ^ lb;
            exp_data.push_back({hb, lb});
        end
`ifdef IMEM_LOADER_CHKSUM_EN
        bq.push_back(x);
`endif
        wr_addr.delete();
        wr_data.delete();
        do_start();
        stream(1'b0);
        wait_done(10);
        check("full_err", 32'(o_Err), 32'd0);
        check_writes("full");

        // Backpressure: random valid gaps give identical writes.
        build_normal(8'h1E);
        wr_addr.delete();
        wr_data.delete();
        do_start();
        stream(1'b1);
        wait_done(10);
        check("bp_err", 32'(o_Err), 32'd0);
        check_writes("bp");

        // Abort by reset right after the third word's write strobe.
        bq.delete();
        bq.push_back(8'h05);
        for (int i = 0; i < 6; i++) bq.push_back(8'($urandom));
        wr_addr.delete();
        wr_data.delete();
        do_start();
        stream(1'b0);
        check("abort_we3", 32'(o_We), 32'd1);
        check("abort_waddr3", 32'(o_Waddr), 32'h0004);
        i_Rst        = 1'b1;
        i_Byte_Valid = 1'b1;
        @(negedge clk);
        check("abort_hold", 32'(o_Cpu_Hold), 32'd0);
        check("abort_ready", 32'(o_Byte_Ready), 32'd0);
        i_Rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_writes", 32'(wr_addr.size()), 32'd3);
        check("abort_idle_ready", 32'(o_Byte_Ready), 32'd0);
        check("abort_idle_done", 32'(o_Done), 32'd0);
        i_Byte_Valid = 1'b0;

`ifdef IMEM_LOADER_CHKSUM_EN
        // Corrupted checksum: error, but both words written.
        build_normal(8'h1F);
        wr_addr.delete();
        wr_data.delete();
        do_start();
        stream(1'b0);
        check("badchk_done", 32'(o_Done), 32'd1);
        check("badchk_err", 32'(o_Err), 32'd1);
        check_writes("badchk");

        // Restart from ERR gives a clean session.
        build_normal(8'h1E);
        wr_addr.delete();
        wr_data.delete();
        do_start();
        check("restart_err_cleared", 32'(o_Err), 32'd0);
        stream(1'b0);
        check("restart_done", 32'(o_Done), 32'd1);
        check("restart_err", 32'(o_Err), 32'd0);
        check_writes("restart");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
